// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port DataMemory between the CPU port (0)
// and the debug/loader port (1), with an optional lock for atomic read-modify-write.
module dmem_arbiter #(
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int LOCK_MAX = 8
) (
  input  logic          CLK,
  input  logic          resetl,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LOCKED} state_t;

  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          lock_q, lock_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          tmo_q, tmo_d;

  logic grant, gsel, own_req, own_lock;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      lock_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      lock_q    <= lock_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    lock_d    = lock_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    tmo_d     = 1'b0;
    grant     = 1'b0;
    gsel      = 1'b0;
    own_req   = owner_q ? req1  : req0;
    own_lock  = owner_q ? lock1 : lock0;

    case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
          grant = 1'b1;
          gsel  = !last_q;
        end else if (req0 || req1) begin
          grant = 1'b1;
          gsel  = req1;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          if (sel_q) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end
        end
        if (lock_q) begin
          state_d = S_LOCKED;
          owner_d = sel_q;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        // Only the owner is looked at; the other port waits until the lock goes.
        if (own_req) begin
          grant = 1'b1;
          gsel  = owner_q;
        end else if (!own_lock) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      state_d = S_ACCESS;
      sel_d   = gsel;
      last_d  = gsel;
      cnt_d   = '0;
      addr_d  = gsel ? addr1  : addr0;
      wdata_d = gsel ? wdata1 : wdata0;
      we_d    = gsel ? we1    : we0;
      lock_d  = gsel ? lock1  : lock0;
    end
  end

  // Strobes decode straight from flops so an async reset drops them at once.
  assign ack0         = (state_q == S_ACCESS) && !sel_q;
  assign ack1         = (state_q == S_ACCESS) &&  sel_q;
  assign mem_read     = (state_q == S_ACCESS) && !we_q;
  assign mem_write    = (state_q == S_ACCESS) &&  we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign lock_timeout = tmo_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table of single accesses, read-data
// scoreboard, and hand-written sequences for alternation, locking, timeout and reset.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [63:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, lock_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] e0, e1;

  dmem_arbiter #(.AW(64), .DW(64), .LOCK_MAX(8)) dut (
    .CLK(CLK), .resetl(resetl),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .lock_timeout(lock_timeout)
  );

  always #5 CLK = ~CLK;

  // Memory model: unwritten locations return a fixed pattern, 0x10 preloaded with 0xDEAD.
  logic [63:0]  tbmem [256];
  logic [255:0] written = '0;

  function automatic logic [63:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 64'hDEAD;
    return {32'hC0DE_0000, 24'h0, a};
  endfunction

  always @(posedge CLK) begin
    if (mem_write) begin
      tbmem[mem_addr[7:0]]   <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
  end

  assign mem_rdata = written[mem_addr[7:0]] ? tbmem[mem_addr[7:0]] : init_val(mem_addr[7:0]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (resetl) begin
      chk("ack_exclusive", {63'b0, ack0 & ack1}, 64'd0);
      chk("strobe_exclusive", {63'b0, mem_read & mem_write}, 64'd0);
      if (rvalid0) begin
        if (q0.size() == 0) chk("rvalid0_unexpected", 64'd1, 64'd0);
        else begin
          e0 = q0.pop_front();
          chk("rdata0", rdata0, e0);
        end
      end
      if (rvalid1) begin
        if (q1.size() == 0) chk("rvalid1_unexpected", 64'd1, 64'd0);
        else begin
          e1 = q1.pop_front();
          chk("rdata1", rdata1, e1);
        end
      end
    end
  end

  // Entered just after a rising edge with the arbiter idle; leaves at the same phase.
  task automatic do_txn(input logic port, input logic we, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] e);
    if (!port) begin req0 = 1'b1; we0 = we; lock0 = 1'b0; addr0 = a; wdata0 = d; end
    else       begin req1 = 1'b1; we1 = we; lock1 = 1'b0; addr1 = a; wdata1 = d; end
    if (!we) begin
      if (!port) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge CLK); @(negedge CLK);
    chk("txn_ack", {63'b0, port ? ack1 : ack0}, 64'd1);
    chk("txn_ack_other", {63'b0, port ? ack0 : ack1}, 64'd0);
    chk("txn_mem_read", {63'b0, mem_read}, {63'b0, !we});
    chk("txn_mem_write", {63'b0, mem_write}, {63'b0, we});
    chk("txn_mem_addr", mem_addr, a);
    if (we) chk("txn_mem_wdata", mem_wdata, d);
    @(posedge CLK); #1;
    if (!port) req0 = 1'b0; else req1 = 1'b0;
    @(negedge CLK);
    chk("txn_rvalid", {63'b0, port ? rvalid1 : rvalid0}, {63'b0, !we});
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD};
    vecs[1] = '{1'b1, 1'b1, 64'h20, 64'h55, 64'h0};
    vecs[2] = '{1'b0, 1'b0, 64'h20, 64'h0, 64'h55};
    vecs[3] = '{1'b1, 1'b0, 64'h30, 64'h0, 64'hC0DE_0000_0000_0030};
    vecs[4] = '{1'b0, 1'b1, 64'h18, 64'h1234_5678_9ABC_DEF0, 64'h0};
    vecs[5] = '{1'b1, 1'b0, 64'h18, 64'h0, 64'h1234_5678_9ABC_DEF0};
    vecs[6] = '{1'b0, 1'b0, 64'hFF, 64'h0, 64'hC0DE_0000_0000_00FF};
    vecs[7] = '{1'b1, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[8] = '{1'b0, 1'b0, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

    resetl = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // Reset values
    @(negedge CLK);
    chk("rst_ack0", {63'b0, ack0}, 64'd0);
    chk("rst_ack1", {63'b0, ack1}, 64'd0);
    chk("rst_rvalid", {62'b0, rvalid0, rvalid1}, 64'd0);
    chk("rst_strobes", {62'b0, mem_read, mem_write}, 64'd0);
    chk("rst_timeout", {63'b0, lock_timeout}, 64'd0);
    chk("rst_rdata0", rdata0, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    @(posedge CLK); #1;
    resetl = 1'b1;

    // Single accesses from the table
    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Both ports requesting continuously from reset: 0,1,0,1 on alternate cycles
    resetl = 1'b0;
    req0 = 1; we0 = 0; addr0 = 64'h40;
    req1 = 1; we1 = 0; addr1 = 64'h48;
    q0.push_back(64'hC0DE_0000_0000_0040); q0.push_back(64'hC0DE_0000_0000_0040);
    q1.push_back(64'hC0DE_0000_0000_0048); q1.push_back(64'hC0DE_0000_0000_0048);
    @(posedge CLK); #1;
    resetl = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge CLK); @(negedge CLK);
      chk("rr_ack0", {63'b0, ack0}, {63'b0, (c % 4) == 0});
      chk("rr_ack1", {63'b0, ack1}, {63'b0, (c % 4) == 2});
    end
    @(posedge CLK); #1;
    req0 = 0; req1 = 0;
    @(posedge CLK); #1;

    // Lock held across a 3-cycle gap; port 1 waits until port 0's unlocking write
    req0 = 1; we0 = 0; lock0 = 1; addr0 = 64'h20;
    q0.push_back(64'h55);
    @(posedge CLK); #1;
    req1 = 1; we1 = 1; addr1 = 64'h28; wdata1 = 64'h77;
    @(negedge CLK);
    chk("lk_ack0", {63'b0, ack0}, 64'd1);
    @(posedge CLK); #1;
    req0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("lk_wait_ack1", {63'b0, ack1}, 64'd0);
      chk("lk_no_timeout", {63'b0, lock_timeout}, 64'd0);
      @(posedge CLK); #1;
    end
    req0 = 1; we0 = 1; lock0 = 0; addr0 = 64'h28; wdata0 = 64'h99;
    @(negedge CLK);
    chk("lk_wait_ack1", {63'b0, ack1}, 64'd0);
    @(posedge CLK); @(negedge CLK);
    chk("lk_wr_ack0", {63'b0, ack0}, 64'd1);
    chk("lk_wr_strobe", {63'b0, mem_write}, 64'd1);
    chk("lk_wr_data", mem_wdata, 64'h99);
    @(posedge CLK); #1;
    req0 = 0; we0 = 0;
    @(negedge CLK);
    chk("lk_idle_ack1", {63'b0, ack1}, 64'd0);
    chk("lk_idle_timeout", {63'b0, lock_timeout}, 64'd0);
    @(posedge CLK); @(negedge CLK);
    chk("lk_ack1", {63'b0, ack1}, 64'd1);
    chk("lk_ack1_data", mem_wdata, 64'h77);
    @(posedge CLK); #1;
    req1 = 0; we1 = 0;
    @(posedge CLK); #1;
    do_txn(1'b0, 1'b0, 64'h28, 64'h0, 64'h77);

    // Lock held while idle: released after 8 locked cycles with a timeout pulse
    req0 = 1; we0 = 0; lock0 = 1; addr0 = 64'h30;
    q0.push_back(64'hC0DE_0000_0000_0030);
    @(posedge CLK); #1;
    req1 = 1; we1 = 0; addr1 = 64'h20;
    q1.push_back(64'h55);
    @(negedge CLK);
    chk("to_ack0", {63'b0, ack0}, 64'd1);
    @(posedge CLK); #1;
    req0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("to_early_timeout", {63'b0, lock_timeout}, 64'd0);
      chk("to_wait_ack1", {63'b0, ack1}, 64'd0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("to_pulse", {63'b0, lock_timeout}, 64'd1);
    chk("to_pulse_ack1", {63'b0, ack1}, 64'd0);
    lock0 = 0;
    @(posedge CLK); @(negedge CLK);
    chk("to_ack1", {63'b0, ack1}, 64'd1);
    chk("to_pulse_end", {63'b0, lock_timeout}, 64'd0);
    @(posedge CLK); #1;
    req1 = 0;
    @(posedge CLK); #1;

    // Asynchronous reset in the middle of an access
    req0 = 1; we0 = 0; addr0 = 64'h10;
    @(posedge CLK); @(negedge CLK);
    chk("ar_ack0", {63'b0, ack0}, 64'd1);
    chk("ar_mem_read", {63'b0, mem_read}, 64'd1);
    #2;
    resetl = 1'b0;
    req0 = 0;
    #1;
    chk("ar_ack_drop", {62'b0, ack0, ack1}, 64'd0);
    chk("ar_strobe_drop", {62'b0, mem_read, mem_write}, 64'd0);
    chk("ar_rdata0", rdata0, 64'd0);
    @(posedge CLK); #1;
    resetl = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("ar_no_rvalid", {62'b0, rvalid0, rvalid1}, 64'd0);
      @(posedge CLK); #1;
    end
    do_txn(1'b1, 1'b0, 64'h20, 64'h0, 64'h55);

    chk("sb_q0_empty", 64'(q0.size()), 64'd0);
    chk("sb_q1_empty", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
